branch_pc_unit: RTL

//  Program-counter and branch-resolution stage directly downstream of the ALU.
//  - Consumes the ALU compare flag (alu_compres) for branches.
//  - Owns the PC and its fetch/flush/halt sequencing.
//  - Counts taken branches for debug.
//  - Resolves each branch over 2 cycles, so the ALU result is sampled only after it has settled.

---
 rtl/branch_pc_unit_pkg.sv | 21 ++
 rtl/branch_pc_unit_sat_counter.sv | 23 ++
 rtl/branch_pc_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC stage.
//  - state_t: FSM encoding (run, resolving a branch, halted).
//  - sext():  sign-extend the low 'w' bits of a 32-bit value to 32 bits.
//             Callers slice the result down to their PC width (PC_WIDTH <= 32).
package branch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_RESOLVE = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < w) ? v[i] : v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_pc_unit_sat_counter.sv
// Saturating up-counter.
//  clock : rising-edge clock
//  clear : synchronous clear (wins over inc)
//  inc   : increment request; ignored once count is all-ones
//  count : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter and branch-resolution stage following the ALU.
// Owns the PC, sequences fetch/flush/halt, and resolves conditional branches
// over two cycles so alu_compres is sampled only after it has settled.
//  clock, reset       : rising-edge clock, synchronous active-high reset
//  instr_valid        : decode presents an instruction
//  stall_in           : downstream hold, freezes advance in run state
//  is_halt/is_jump/is_branch : instruction class (halt > jump > branch)
//  jump_target        : absolute jump destination
//  branch_off         : signed PC-relative branch offset
//  alu_compres        : ALU compare result, sampled in the resolve cycle
//  pc                 : registered fetch address
//  fetch_en           : imem may fetch at pc
//  flush              : 1-cycle pulse after a jump or taken branch
//  busy               : branch resolution in progress
//  halted             : core halted (only reset leaves)
//  taken_cnt          : saturating taken-branch count
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int                     PC_WIDTH  = 16,
  parameter int                     OFF_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter int                     CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic                 stall_in,
  input  logic                 is_halt,
  input  logic                 is_jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 is_branch,
  input  logic [OFF_WIDTH-1:0] branch_off,
  input  logic                 alu_compres,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 flush,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  state_t               state;
  logic [PC_WIDTH-1:0]  base;
  logic [OFF_WIDTH-1:0] off;
  logic [31:0]          off_sext32;
  logic [PC_WIDTH-1:0]  off_ext;
  logic                 advance;
  logic                 taken;

  assign advance    = instr_valid & ~stall_in & (state == S_RUN);
  assign off_sext32 = sext({{(32-OFF_WIDTH){1'b0}}, off}, OFF_WIDTH);
  assign off_ext    = off_sext32[PC_WIDTH-1:0];
  assign taken      = (state == S_RESOLVE) & alu_compres;

  // Fetch is gated directly by stall so a held downstream stops fetch the same cycle.
  assign fetch_en   = (state == S_RUN) & ~stall_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_RUN;
      pc     <= RESET_PC;
      flush  <= 1'b0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        S_RUN: begin
          if (advance) begin
            if (is_halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (is_jump) begin
              pc    <= jump_target;
              flush <= 1'b1;
            end else if (is_branch) begin
              // pc holds; the resolve cycle computes the target from base.
              base  <= pc;
              off   <= branch_off;
              state <= S_RESOLVE;
              busy  <= 1'b1;
            end else begin
              pc <= pc + PC_WIDTH'(1);
            end
          end
        end
        S_RESOLVE: begin
          state <= S_RUN;
          busy  <= 1'b0;
          if (alu_compres) begin
            pc    <= base + off_ext;
            flush <= 1'b1;
          end else begin
            pc <= base + PC_WIDTH'(1);
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= S_RUN;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (taken),
    .count (taken_cnt)
  );

endmodule
